async_fifo_write_arbiter: RTL and testbench

Write-domain arbiter that shares the single write port of async_fifo among NREQ requesters. Uses round-robin arbitration with bounded bursts and respects p_write_full backpressure. Sits between several producer blocks and async_fifo: drives p_write_en and p_write_data, and samples p_write_full. Runs entirely in the write clock domain.

---
 rtl/async_fifo_write_arbiter.sv | 119 +++++++++++
 tb/tb_async_fifo_write_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_write_arbiter.sv
// Write-domain arbiter sharing the single async_fifo write port among NREQ
// producers. Round-robin winner selection, bursts bounded to MAX_BURST beats,
// and beats are only issued while the FIFO reports not-full.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no owner; choose the next valid requester after last_owner
// S_GRANT | owner streams beats until burst limit or it drops valid
module async_fifo_write_arbiter #(
    parameter int BITS      = 32,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                    write_clk,
    input  logic                    write_rst_n,
    input  logic [NREQ-1:0]         p_req_valid,
    input  logic [NREQ*BITS-1:0]    p_req_data,
    output logic [NREQ-1:0]         p_req_ready,
    output logic                    p_write_en,
    output logic [BITS-1:0]         p_write_data,
    input  logic                    p_write_full,
    output logic [$clog2(NREQ)-1:0] p_grant_id,
    output logic                    p_busy
);

    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state_q;
    logic [IDW-1:0]  owner_q;
    logic [IDW-1:0]  last_owner_q;
    logic [CNTW-1:0] beat_cnt_q;

    logic [CNTW-1:0] beat_cnt_d;
    logic            in_grant;
    logic            owner_valid;
    logic            beat;
    logic            burst_done;

    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  winner;
    logic            winner_found;

    logic [BITS-1:0] req_data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_data_arr[g] = p_req_data[g*BITS +: BITS];
    end

    assign in_grant    = (state_q == S_GRANT);
    assign owner_valid = p_req_valid[owner_q];
    // A beat needs an owner holding valid and room in the FIFO; full wins.
    assign beat        = in_grant & owner_valid & ~p_write_full;
    assign beat_cnt_d  = beat_cnt_q + CNTW'(1);
    assign burst_done  = (beat_cnt_d == CNTW'(MAX_BURST));

    assign p_write_en   = beat;
    assign p_req_ready  = beat ? (NREQ'(1) << owner_q) : '0;
    assign p_write_data = in_grant ? req_data_arr[owner_q] : '0;
    assign p_busy       = in_grant;
    assign p_grant_id   = owner_q;

    // Round-robin search: first valid index starting just after last_owner.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        cand         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_owner_q) + k) % NREQ);
            if (!winner_found && p_req_valid[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    // Arbitration FSM with owner, fairness pointer and burst counter.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDW'(NREQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (winner_found) begin
                        owner_q    <= winner;
                        beat_cnt_q <= '0;
                        state_q    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!owner_valid) begin
                        // Owner released early; full is irrelevant here.
                        state_q      <= S_IDLE;
                        last_owner_q <= owner_q;
                    end else if (beat) begin
                        beat_cnt_q <= beat_cnt_d;
                        if (burst_done) begin
                            state_q      <= S_IDLE;
                            last_owner_q <= owner_q;
                        end
                    end
                    // Otherwise backpressured: hold owner and count.
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_async_fifo_write_arbiter.sv
// Self-checking bench for async_fifo_write_arbiter (BITS=32, NREQ=4, MAX_BURST=4).
module tb_async_fifo_write_arbiter;

    localparam int BITS      = 32;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   valid;
    logic [NREQ*BITS-1:0] data;
    logic [NREQ-1:0]   ready;
    logic              en;
    logic [BITS-1:0]   wdata;
    logic              full;
    logic [1:0]        gid;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    async_fifo_write_arbiter #(.BITS(BITS), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
        .write_clk    (clk),
        .write_rst_n  (rst_n),
        .p_req_valid  (valid),
        .p_req_data   (data),
        .p_req_ready  (ready),
        .p_write_en   (en),
        .p_write_data (wdata),
        .p_write_full (full),
        .p_grant_id   (gid),
        .p_busy       (busy)
    );

    typedef struct {
        logic [3:0]  v;
        logic        f;
        logic        en;
        logic [3:0]  rdy;
        logic [1:0]  gid;
        logic        busy;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_dat(input int i, input logic [31:0] v);
        data[i*BITS +: BITS] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = '0;
        full  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Single requester, full schedule and expected write_en per cycle.
    task automatic run_one(input string tag, input int id, input int nbeats,
                           input logic [31:0] base, input logic [15:0] full_pat,
                           input logic [15:0] en_pat, input int ncyc);
        int   seq;
        logic got;
        seq = 0;
        for (int c = 0; c < ncyc; c++) begin
            valid = (seq < nbeats) ? (4'b0001 << id) : 4'b0000;
            set_dat(id, base + 32'(seq));
            full = full_pat[c];
            #1;
            chk($sformatf("%s_en_c%0d", tag, c), {31'b0, en}, {31'b0, en_pat[c]});
            if (en) begin
                chk($sformatf("%s_data_c%0d", tag, c), wdata, base + 32'(seq));
                chk($sformatf("%s_gid_c%0d", tag, c), {30'b0, gid}, 32'(id));
                chk($sformatf("%s_rdy_c%0d", tag, c), {28'b0, ready}, 32'(4'b0001 << id));
            end else begin
                chk($sformatf("%s_rdy0_c%0d", tag, c), {28'b0, ready}, 32'h0);
            end
            if (full_pat[c] && busy)
                chk($sformatf("%s_cnt_hold_c%0d", tag, c), 32'(dut.beat_cnt_q), 32'(seq % MAX_BURST));
            got = en;
            @(posedge clk);
            #1;
            if (got) seq++;
        end
        full = 1'b0;
        chk($sformatf("%s_total", tag), 32'(seq), 32'(nbeats));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int   beats;
        int   s [4];
        int   exp_owner;
        logic [3:0] r;
        int   wseq [4];
        int   rseq [4];
        int   wr_cnt;
        int   id;
        int   cyc;
        logic [31:0] q [$];
        logic [31:0] x;

        tbl[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 32'h0};
        tbl[1]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 32'h0};
        tbl[2]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 32'hD000_0002};
        tbl[3]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1, 32'hD000_0002};
        tbl[4]  = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 32'hD000_0002};
        tbl[5]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1, 32'hD000_0002};
        tbl[6]  = '{4'b1011, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 32'h0};
        tbl[7]  = '{4'b1011, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 32'hD000_0003};
        tbl[8]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1, 32'hD000_0003};
        tbl[9]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 32'h0};
        tbl[10] = '{4'b0011, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 32'hD000_0000};
        tbl[11] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 32'hD000_0000};
        tbl[12] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 32'hD000_0000};
        tbl[13] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 32'hD000_0000};
        tbl[14] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 32'hD000_0000};
        tbl[15] = '{4'b0011, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 32'h0};
        tbl[16] = '{4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 32'hD000_0001};
        tbl[17] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1, 32'hD000_0001};
        tbl[18] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 32'h0};

        // Reset hold, first grant after release, async reset mid-burst.
        rst_n = 1'b0;
        valid = 4'b1111;
        full  = 1'b0;
        for (int i = 0; i < NREQ; i++) set_dat(i, 32'hA000_0000 + 32'(i));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", {31'b0, en}, 32'h0);
        chk("rst_rdy", {28'b0, ready}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_gid", {30'b0, gid}, 32'h0);
        chk("rst_data", wdata, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_idle_busy", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
        chk("rel_first_gid", {30'b0, gid}, 32'h0);
        chk("rel_first_rdy", {28'b0, ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("midburst_en", {31'b0, en}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_en", {31'b0, en}, 32'h0);
        chk("async_rst_rdy", {28'b0, ready}, 32'h0);
        chk("async_rst_busy", {31'b0, busy}, 32'h0);
        chk("async_rst_gid", {30'b0, gid}, 32'h0);
        chk("async_rst_data", wdata, 32'h0);

        // Table-driven vectors.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_dat(i, 32'hD000_0000 + 32'(i));
        for (int i = 0; i < 19; i++) begin
            valid = tbl[i].v;
            full  = tbl[i].f;
            #1;
            chk($sformatf("tbl%0d_en", i), {31'b0, en}, {31'b0, tbl[i].en});
            chk($sformatf("tbl%0d_rdy", i), {28'b0, ready}, {28'b0, tbl[i].rdy});
            chk($sformatf("tbl%0d_gid", i), {30'b0, gid}, {30'b0, tbl[i].gid});
            chk($sformatf("tbl%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].busy});
            chk($sformatf("tbl%0d_data", i), wdata, tbl[i].wd);
            @(posedge clk);
            #1;
        end

        // Single requester: 4-beat burst, arbitration gap, 2 more beats.
        do_reset();
        run_one("single", 2, 6, 32'h200, 16'h0000, 16'h00DE, 9);

        // Backpressure after beat 2 for three cycles.
        do_reset();
        run_one("bp", 0, 4, 32'h400, 16'h0038, 16'h00C6, 9);

        // Fairness: all four continuously valid.
        do_reset();
        for (int i = 0; i < 4; i++) s[i] = 0;
        beats = 0;
        valid = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < 4; i++) set_dat(i, (32'(i) << 16) | 32'(s[i]));
            #1;
            if (en) begin
                exp_owner = (beats / MAX_BURST) % NREQ;
                chk($sformatf("fair_gid_b%0d", beats), {30'b0, gid}, 32'(exp_owner));
                chk($sformatf("fair_data_b%0d", beats), wdata,
                    (32'(exp_owner) << 16) | 32'(s[exp_owner]));
                beats++;
            end
            r = ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) if (r[i]) s[i]++;
        end
        chk("fair_beats_in_20", 32'(beats), 32'd16);
        #1;
        chk("fair_gap_busy", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
        chk("fair_wrap_gid", {30'b0, gid}, 32'h0);
        chk("fair_wrap_en", {31'b0, en}, 32'h1);

        // Early release by req1, then req3, then req0.
        do_reset();
        set_dat(0, 32'h500);
        set_dat(1, 32'h501);
        set_dat(3, 32'h503);
        valid = 4'b1010;
        #1;
        chk("early_idle_busy", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
        chk("early_gid1", {30'b0, gid}, 32'h1);
        chk("early_data1", wdata, 32'h501);
        chk("early_rdy1", {28'b0, ready}, 32'h2);
        @(posedge clk);
        #1;
        valid = 4'b1000;
        #1;
        chk("early_drop_en", {31'b0, en}, 32'h0);
        chk("early_drop_busy", {31'b0, busy}, 32'h1);
        @(posedge clk);
        #1;
        chk("early_rearb_busy", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
        valid = 4'b1001;
        #1;
        chk("early_gid3", {30'b0, gid}, 32'h3);
        chk("early_rdy3", {28'b0, ready}, 32'h8);
        repeat (4) @(posedge clk);
        #1;
        chk("early_after3_busy", {31'b0, busy}, 32'h0);
        valid = 4'b0001;
        @(posedge clk);
        #1;
        chk("early_gid0", {30'b0, gid}, 32'h0);
        chk("early_rdy0", {28'b0, ready}, 32'h1);

        // End-to-end with a depth-8 FIFO model and random valid gaps.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s[i] = 0; wseq[i] = 0; rseq[i] = 0;
        end
        wr_cnt = 0;
        cyc = 0;
        while (wr_cnt < 64 && cyc < 4000) begin
            full = (q.size() >= 8);
            for (int i = 0; i < 4; i++) begin
                if (!valid[i] && s[i] < 16 && $urandom_range(0, 2) == 0) valid[i] = 1'b1;
                set_dat(i, (32'(i) << 16) | 32'(s[i]));
            end
            #1;
            if (en) begin
                chk("e2e_no_write_when_full", {31'b0, full}, 32'h0);
                id = int'(wdata[31:16]);
                if (id < 4) begin
                    chk("e2e_rdy_match", {28'b0, ready}, 32'(4'b0001 << id));
                    chk($sformatf("e2e_wseq_id%0d", id), {16'b0, wdata[15:0]}, 32'(wseq[id]));
                    wseq[id]++;
                end else begin
                    chk("e2e_id_range", 32'(id), 32'd0);
                end
                q.push_back(wdata);
                wr_cnt++;
            end
            r = ready;
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < 4; i++) if (r[i]) begin
                valid[i] = 1'b0;
                s[i]++;
            end
            if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
                x = q.pop_front();
                id = int'(x[31:16]);
                if (id < 4) begin
                    chk($sformatf("e2e_rseq_id%0d", id), {16'b0, x[15:0]}, 32'(rseq[id]));
                    rseq[id]++;
                end
            end
        end
        chk("e2e_total_writes", 32'(wr_cnt), 32'd64);
        while (q.size() > 0) begin
            x = q.pop_front();
            id = int'(x[31:16]);
            if (id < 4) begin
                chk($sformatf("e2e_drain_id%0d", id), {16'b0, x[15:0]}, 32'(rseq[id]));
                rseq[id]++;
            end
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("e2e_count_id%0d", i), 32'(rseq[i]), 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
